io_map_sequencer: RTL and testbench

- APB2 master that keeps the IO multiplexer's physical/logical map table consistent, one host command at a time.
- Sits between a host command source (SPI/control FSM) and the APB2 port of the IO multiplexer slave.
- Each command becomes a sequence of read-check-write transfers, so a logical pin is never left mapped to two physical pins, and no physical pin is left claimed by a stale logical pin.

---
 rtl/io_map_pkg.sv | 29 ++
 rtl/apb2_master_xfer.sv | 53 +++++
 rtl/io_map_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_io_map_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared op codes, unmapped marker and sequencer state encoding for the IO map sequencer.
package io_map_pkg;

    typedef enum logic [1:0] {
        OP_MAP   = 2'd0,
        OP_UNMAP = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    localparam logic [7:0] NO_MAP = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        RD_LOG,
        RD_PHY,
        WR_OLDP,
        WR_OLDL,
        WR_PHY,
        WR_LOG,
        CLR,
        DONE
    } state_e;

    function automatic logic is_xfer(input state_e s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/apb2_master_xfer.sv
// Two-cycle APB2 transfer engine: SETUP then ACCESS; a start during ACCESS chains the next
// transfer with no idle cycle. Bus outputs are registered and cleared asynchronously by rst.
module apb2_master_xfer #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 last,
    output logic [DATA_BITS-1:0] rd_dat,
    output logic [ADDR_BITS-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [DATA_BITS-1:0] PWDATA,
    input  logic [DATA_BITS-1:0] PRDATA
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (start) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= write;
            PADDR   <= addr;
            PWDATA  <= wdata;
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else if (PSEL) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end
    end

    // Read data is valid during the last cycle and is sampled by the caller on that edge.
    assign busy   = PSEL;
    assign last   = PSEL && PENABLE;
    assign rd_dat = PRDATA;

endmodule

// File: rtl/io_map_sequencer.sv
// APB2 master keeping the physical/logical IO map table consistent, one command at a time.
// Each command is a chain of back-to-back read-check-write transfers; done pulses after the last.
module io_map_sequencer
    import io_map_pkg::*;
#(
    parameter int IO_PHYSICAL = 16,
    parameter int IO_LOGICAL  = 8,
    parameter int ADDR_BITS   = 12,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [7:0]           cmd_logical,
    input  logic [7:0]           cmd_physical,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_BITS-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [DATA_BITS-1:0] PWDATA,
    input  logic [DATA_BITS-1:0] PRDATA
);

    localparam int              TOTAL    = IO_PHYSICAL + IO_LOGICAL;
    localparam int              CNT_W    = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
    localparam logic [7:0]      PHY_N    = 8'(IO_PHYSICAL);
    localparam logic [7:0]      LOG_N    = 8'(IO_LOGICAL);

    state_e             state, state_n;
    op_e                op_q, op_c;
    logic [7:0]         l_q, l_c, p_q, p_c;
    logic [7:0]         pold_q, pold_c, lold_q, lold_c;
    logic [CNT_W-1:0]   cnt_q, cnt_c;
    logic               err_q;
    logic               bad_cmd, skip_p, skip_l;

    logic                 x_start, x_write, x_busy, x_last;
    logic [ADDR_BITS-1:0] x_addr;
    logic [DATA_BITS-1:0] x_wdata, x_rd;

    function automatic logic [ADDR_BITS-1:0] phy_ent(input logic [7:0] idx);
        return ADDR_BITS'(idx);
    endfunction

    function automatic logic [ADDR_BITS-1:0] log_ent(input logic [7:0] idx);
        return ADDR_BITS'(IO_PHYSICAL) + ADDR_BITS'(idx);
    endfunction

    assign bad_cmd = (cmd_op == OP_RSVD) || (cmd_logical >= LOG_N) ||
                     ((cmd_op == OP_MAP) && (cmd_physical >= PHY_N));

    // Current-cycle view of the command and captured reads, including data sampled on this edge.
    always_comb begin
        op_c   = op_q;
        l_c    = l_q;
        p_c    = p_q;
        pold_c = pold_q;
        lold_c = lold_q;
        cnt_c  = cnt_q;
        if (state == IDLE) begin
            op_c  = op_e'(cmd_op);
            l_c   = cmd_logical;
            p_c   = cmd_physical;
            cnt_c = '0;
        end
        if (state == RD_LOG && x_last) pold_c = 8'(x_rd);
        if (state == RD_PHY && x_last) lold_c = 8'(x_rd);
        if (state == CLR && x_last)    cnt_c  = cnt_q + CNT_W'(1);
    end

    // The P==Pold exemption only makes sense for MAP; UNMAP must always free the old physical pin.
    assign skip_p = (pold_c == NO_MAP) || (pold_c >= PHY_N) ||
                    ((op_c == OP_MAP) && (pold_c == p_c));
    assign skip_l = (lold_c == NO_MAP) || (lold_c >= LOG_N) || (lold_c == l_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_MAP;
            l_q    <= '0;
            p_q    <= '0;
            pold_q <= NO_MAP;
            lold_q <= NO_MAP;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_c;
            l_q    <= l_c;
            p_q    <= p_c;
            pold_q <= pold_c;
            lold_q <= lold_c;
            cnt_q  <= cnt_c;
            if (state == IDLE) err_q <= bad_cmd;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (bad_cmd)                   state_n = DONE;
                    else if (op_c == OP_CLEAR)     state_n = CLR;
                    else                           state_n = RD_LOG;
                end
            end
            RD_LOG: begin
                if (x_last) begin
                    if (op_c == OP_MAP)            state_n = RD_PHY;
                    else if (skip_p)               state_n = WR_LOG;
                    else                           state_n = WR_OLDP;
                end
            end
            RD_PHY: begin
                if (x_last) begin
                    if (!skip_p)                   state_n = WR_OLDP;
                    else if (!skip_l)              state_n = WR_OLDL;
                    else                           state_n = WR_PHY;
                end
            end
            WR_OLDP: begin
                if (x_last) begin
                    if (op_c != OP_MAP)            state_n = WR_LOG;
                    else if (!skip_l)              state_n = WR_OLDL;
                    else                           state_n = WR_PHY;
                end
            end
            WR_OLDL: if (x_last) state_n = WR_PHY;
            WR_PHY:  if (x_last) state_n = WR_LOG;
            WR_LOG:  if (x_last) state_n = DONE;
            CLR:     if (x_last && cnt_q == CNT_LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        x_addr  = '0;
        x_write = 1'b0;
        x_wdata = '0;
        case (state_n)
            RD_LOG:  x_addr = log_ent(l_c);
            RD_PHY:  x_addr = phy_ent(p_c);
            WR_OLDP: begin x_addr = phy_ent(pold_c); x_write = 1'b1; x_wdata = DATA_BITS'(NO_MAP); end
            WR_OLDL: begin x_addr = log_ent(lold_c); x_write = 1'b1; x_wdata = DATA_BITS'(NO_MAP); end
            WR_PHY:  begin x_addr = phy_ent(p_c);    x_write = 1'b1; x_wdata = DATA_BITS'(l_c);    end
            WR_LOG:  begin
                x_addr  = log_ent(l_c);
                x_write = 1'b1;
                x_wdata = (op_c == OP_MAP) ? DATA_BITS'(p_c) : DATA_BITS'(NO_MAP);
            end
            CLR:     begin x_addr = ADDR_BITS'(cnt_c); x_write = 1'b1; x_wdata = DATA_BITS'(NO_MAP); end
            default: ;
        endcase
    end

    assign x_start = is_xfer(state_n) && (!x_busy || x_last);

    always_comb begin
        cmd_ready = (state == IDLE);
        done      = (state == DONE);
        err       = (state == DONE) && err_q;
    end

    apb2_master_xfer #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start   (x_start),
        .addr    (x_addr),
        .write   (x_write),
        .wdata   (x_wdata),
        .busy    (x_busy),
        .last    (x_last),
        .rd_dat  (x_rd),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA)
    );

endmodule

// File: tb/tb_io_map_sequencer.sv
// Directed bench for io_map_sequencer against a behavioural APB2 map-table slave.
module tb_io_map_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_logical;
    logic [7:0]  cmd_physical;
    logic        done;
    logic        err;
    logic [11:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_map_sequencer #(
        .IO_PHYSICAL (16),
        .IO_LOGICAL  (8),
        .ADDR_BITS   (12),
        .DATA_BITS   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_logical  (cmd_logical),
        .cmd_physical (cmd_physical),
        .done         (done),
        .err          (err),
        .PADDR        (PADDR),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA)
    );

    // Slave memory and bus monitor
    logic [7:0]  mem [0:23];
    logic [16:0] got_q [$];
    logic        prev_setup;
    logic [11:0] s_addr;
    logic        s_wr;
    logic [7:0]  s_wd;
    int          proto_viol = 0;
    int          busy_cnt = 0;
    int          viol_now;

    assign PRDATA = (PSEL && PADDR < 12'd24) ? mem[PADDR[4:0]] : 8'h00;

    assign viol_now = int'(PENABLE && !prev_setup)
                    + int'(PSEL && PENABLE && (PADDR != s_addr || PWRITE != s_wr || PWDATA != s_wd))
                    + int'(!PSEL && (PENABLE || PWRITE || PADDR != 12'd0 || PWDATA != 8'd0));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 24; i++) mem[i] <= 8'hFF;
            prev_setup <= 1'b0;
            s_addr     <= 12'd0;
            s_wr       <= 1'b0;
            s_wd       <= 8'd0;
        end else begin
            proto_viol <= proto_viol + viol_now;
            prev_setup <= PSEL && !PENABLE;
            s_addr     <= PADDR;
            s_wr       <= PWRITE;
            s_wd       <= PWDATA;
            if (PSEL) busy_cnt <= busy_cnt + 1;
            if (PSEL && PENABLE) begin
                got_q.push_back({PWRITE, PADDR[7:0], PWRITE ? PWDATA : 8'h00});
                if (PWRITE && PADDR < 12'd24) mem[PADDR[4:0]] <= PWDATA;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] rd(input int a);
        return {1'b0, 8'(a), 8'h00};
    endfunction

    function automatic logic [16:0] wr(input int a, input int d);
        return {1'b1, 8'(a), 8'(d)};
    endfunction

    typedef struct {
        logic [1:0] op;
        logic [7:0] l;
        logic [7:0] p;
        logic       e;
        int         cyc;
        int         n;
    } vec_t;

    vec_t        vecs [9];
    logic [16:0] exp_q [$];

    task automatic run_cmd(input vec_t v, input string tag);
        int cyc;
        int base;
        @(negedge clk);
        check({tag, "_ready_before"}, cmd_ready, 1);
        base         = got_q.size();
        cmd_valid    = 1'b1;
        cmd_op       = v.op;
        cmd_logical  = v.l;
        cmd_physical = v.p;
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_op       = v.op ^ 2'd1;
        cmd_logical  = v.l + 8'd1;
        cmd_physical = v.p + 8'd3;
        check({tag, "_ready_low"}, cmd_ready, 0);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_done_cycle"}, cyc, v.cyc);
        check({tag, "_err"}, err, v.e);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_after"}, cmd_ready, 1);
        check({tag, "_xfer_count"}, got_q.size() - base, v.n);
        for (int k = 0; k < v.n; k++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_exp_underflow"}, 1, 0);
                break;
            end
            if (base + k < got_q.size())
                check($sformatf("%s_xfer%0d", tag, k), got_q[base + k], exp_q[0]);
            else
                check($sformatf("%s_xfer%0d_missing", tag, k), 0, exp_q[0]);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        vec_t extra;
        int   busy_before;

        vecs[0] = '{2'd0, 8'd2, 8'd5,   1'b0, 9,  4};
        vecs[1] = '{2'd0, 8'd2, 8'd7,   1'b0, 11, 5};
        vecs[2] = '{2'd0, 8'd3, 8'd7,   1'b0, 11, 5};
        vecs[3] = '{2'd1, 8'd3, 8'hFF,  1'b0, 7,  3};
        vecs[4] = '{2'd1, 8'd4, 8'hFF,  1'b0, 5,  2};
        vecs[5] = '{2'd0, 8'd8, 8'd0,   1'b1, 1,  0};
        vecs[6] = '{2'd0, 8'd0, 8'd16,  1'b1, 1,  0};
        vecs[7] = '{2'd3, 8'd0, 8'd0,   1'b1, 1,  0};
        vecs[8] = '{2'd2, 8'd0, 8'd0,   1'b0, 49, 24};

        exp_q.push_back(rd(18)); exp_q.push_back(rd(5));
        exp_q.push_back(wr(5, 8'h02)); exp_q.push_back(wr(18, 8'h05));
        exp_q.push_back(rd(18)); exp_q.push_back(rd(7)); exp_q.push_back(wr(5, 8'hFF));
        exp_q.push_back(wr(7, 8'h02)); exp_q.push_back(wr(18, 8'h07));
        exp_q.push_back(rd(19)); exp_q.push_back(rd(7)); exp_q.push_back(wr(18, 8'hFF));
        exp_q.push_back(wr(7, 8'h03)); exp_q.push_back(wr(19, 8'h07));
        exp_q.push_back(rd(19)); exp_q.push_back(wr(7, 8'hFF)); exp_q.push_back(wr(19, 8'hFF));
        exp_q.push_back(rd(20)); exp_q.push_back(wr(20, 8'hFF));
        for (int a = 0; a < 24; a++) exp_q.push_back(wr(a, 8'hFF));

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'd0;
        cmd_logical  = 8'd0;
        cmd_physical = 8'd0;
        #3;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
            if (i == 2) begin
                check("tbl_p7", mem[7], 8'h03);
                check("tbl_l3", mem[19], 8'h07);
                check("tbl_l2", mem[18], 8'hFF);
                check("tbl_p5", mem[5], 8'hFF);
            end
        end
        for (int a = 0; a < 24; a++)
            if (mem[a] != 8'hFF) check($sformatf("clear_entry%0d", a), mem[a], 8'hFF);

        // Reset in the ACCESS phase of a CLEAR_ALL write
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_clear_penable", PENABLE, 1);
        rst = 1'b1;
        #1;
        check("async_psel", PSEL, 0);
        check("async_penable", PENABLE, 0);
        check("async_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        busy_before = busy_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_quiet", busy_cnt - busy_before, 0);
        check("post_rst_ready", cmd_ready, 1);

        extra = '{2'd0, 8'd0, 8'd0, 1'b0, 9, 4};
        exp_q.push_back(rd(16)); exp_q.push_back(rd(0));
        exp_q.push_back(wr(0, 8'h00)); exp_q.push_back(wr(16, 8'h00));
        run_cmd(extra, "post_rst_map");

        check("apb_protocol_violations", proto_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
